// File: rtl/css_mcu0_dmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : css_mcu0_dmi_pkg
// Description : Shared types and widths for the MCU0 DMI arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package css_mcu0_dmi_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dmi_arb_state_e;

    // Fields captured from the winning requester at acceptance
    typedef struct packed {
        logic                  wr;
        logic [DMI_ADDR_W-1:0] addr;
        logic [DMI_DATA_W-1:0] wdata;
    } dmi_req_t;

endpackage
`default_nettype wire

// File: rtl/css_mcu0_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : css_mcu0_rr_arb2
// Description : 2-way grant logic, round-robin or fixed priority to req[0].
//               The favoured-requester pointer moves to the other requester
//               whenever a transaction completes.
// Revision    : 1.0 - initial release
// ============================================================================
module css_mcu0_rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic r_rr_ptr;

    // Pointer favours the requester that was not served last
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (upd) begin
            r_rr_ptr <= ~upd_id;
        end
    end

    // A lone requester always wins; ties go to the pointer (or req 0 if fixed)
    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (req == 2'b11) begin
            gnt_id = FIXED_PRIO ? 1'b0 : r_rr_ptr;
            gnt    = gnt_id ? 2'b10 : 2'b01;
        end else begin
            gnt    = req;
            gnt_id = req[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/css_mcu0_dmi_arb.sv
`default_nettype none
// ============================================================================
// Module      : css_mcu0_dmi_arb
// Description : Shares one upstream DMI port between the JTAG DTM (req 0)
//               and the internal debug agent (req 1). One transaction in
//               flight: accept, one-cycle dmi_en strobe, fixed read latency,
//               one-cycle response pulse to the granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module css_mcu0_dmi_arb
    import css_mcu0_dmi_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_wr,
    input  logic [DMI_ADDR_W-1:0] req0_addr,
    input  logic [DMI_DATA_W-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DMI_DATA_W-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_wr,
    input  logic [DMI_ADDR_W-1:0] req1_addr,
    input  logic [DMI_DATA_W-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DMI_DATA_W-1:0] rsp1_rdata,
    output logic                  dmi_en,
    output logic                  dmi_wr_en,
    output logic [DMI_ADDR_W-1:0] dmi_addr,
    output logic [DMI_DATA_W-1:0] dmi_wdata,
    input  logic [DMI_DATA_W-1:0] dmi_rdata,
    output logic                  busy
);

    // WAIT runs RD_LAT cycles, counting down to zero
    localparam logic [2:0] C_LAT_LOAD = 3'(RD_LAT - 1);

    dmi_arb_state_e r_state;
    dmi_req_t       r_req;
    logic           r_gid;
    logic [2:0]     r_cnt;

    logic [1:0]     w_gnt;
    logic           w_gnt_id;
    logic           w_idle;
    logic           w_accept;
    logic           w_issue;
    dmi_req_t       w_sel_req;

    assign w_idle   = (r_state == IDLE);
    assign w_issue  = (r_state == ISSUE);
    assign w_accept = w_idle & (|w_gnt);

    css_mcu0_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .upd    (r_state == RESP),
        .upd_id (r_gid),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    // Ready is only offered while idle, so a busy arbiter holds requesters off
    assign req0_ready = w_idle & w_gnt[0];
    assign req1_ready = w_idle & w_gnt[1];

    // Fields of whichever requester is being granted this cycle
    always_comb begin
        w_sel_req = '0;
        if (w_gnt_id) begin
            w_sel_req.wr    = req1_wr;
            w_sel_req.addr  = req1_addr;
            w_sel_req.wdata = req1_wdata;
        end else begin
            w_sel_req.wr    = req0_wr;
            w_sel_req.addr  = req0_addr;
            w_sel_req.wdata = req0_wdata;
        end
    end

    // Downstream bus is quiet except during the single ISSUE cycle
    assign dmi_en    = w_issue;
    assign dmi_wr_en = w_issue & r_req.wr;
    assign dmi_addr  = w_issue ? r_req.addr  : '0;
    assign dmi_wdata = w_issue ? r_req.wdata : '0;
    assign busy      = ~w_idle;

    // Transaction sequencer: accept, issue, wait out latency, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_gid      <= 1'b0;
            r_cnt      <= 3'd0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req   <= w_sel_req;
                        r_gid   <= w_gnt_id;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= C_LAT_LOAD;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == 3'd0) begin
                        // Capture straight into the winner's response register;
                        // the other requester's data is left untouched
                        if (r_gid) begin
                            rsp1_rdata <= dmi_rdata;
                            rsp1_valid <= 1'b1;
                        end else begin
                            rsp0_rdata <= dmi_rdata;
                            rsp0_valid <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
